// File: rtl/y86_pkg.sv
// -----------------------------------------------------------------------------
// y86_pkg
// Shared definitions for the SEQ Y86-64 stage controller: instruction codes,
// processor status codes, the controller state encoding, stage-enable bit
// positions and small decode helpers used by the controller.
// No ports (package).
// -----------------------------------------------------------------------------
package y86_pkg;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Processor status codes
    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    // Controller states
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPDATE  = 3'd6,
        S_HALT      = 3'd7
    } state_e;

    // Stage-enable bit positions: {pcupd,wb,mem,exe,dec,fetch}
    localparam int STG_W     = 6;
    localparam int STG_FETCH = 0;
    localparam int STG_DEC   = 1;
    localparam int STG_EXE   = 2;
    localparam int STG_MEM   = 3;
    localparam int STG_WB    = 4;
    localparam int STG_PCUPD = 5;

    // One-hot stage enable for a state; IDLE and HALT enable nothing.
    function automatic logic [STG_W-1:0] stage_onehot(input state_e s);
        logic [STG_W-1:0] oh;
        oh = '0;
        case (s)
            S_FETCH:     oh[STG_FETCH] = 1'b1;
            S_DECODE:    oh[STG_DEC]   = 1'b1;
            S_EXECUTE:   oh[STG_EXE]   = 1'b1;
            S_MEMORY:    oh[STG_MEM]   = 1'b1;
            S_WRITEBACK: oh[STG_WB]    = 1'b1;
            S_PCUPDATE:  oh[STG_PCUPD] = 1'b1;
            default:     oh = '0;
        endcase
        return oh;
    endfunction

    // Instructions that access data memory.
    function automatic logic is_mem_icode(input logic [3:0] ic);
        logic r;
        case (ic)
            I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
            default:                                            r = 1'b0;
        endcase
        return r;
    endfunction

    // Instructions writing valE to dstE; cmovxx only when its condition holds.
    function automatic logic writes_e(input logic [3:0] ic, input logic cnd_v);
        logic r;
        case (ic)
            I_IRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: r = 1'b1;
            I_RRMOVQ:                                        r = cnd_v;
            default:                                         r = 1'b0;
        endcase
        return r;
    endfunction

    // Instructions writing valM to dstM.
    function automatic logic writes_m(input logic [3:0] ic);
        logic r;
        case (ic)
            I_MRMOVQ, I_POPQ: r = 1'b1;
            default:          r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_perf_counter.sv
// -----------------------------------------------------------------------------
// seq_perf_counter
// One saturating up-counter with enable. Holds at all-ones once reached.
// Only elaborated when SEQ_PERF_CNT_EN is defined (performance counters).
// Ports:
//   clk    in  1      system clock, rising edge
//   rst_n  in  1      asynchronous active-low reset, clears the count
//   en_i   in  1      count enable
//   cnt_o  out CNT_W  current count
// -----------------------------------------------------------------------------
`ifdef SEQ_PERF_CNT_EN
module seq_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: increment when enabled, saturating at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule
`endif

// File: rtl/seq_stage_controller.sv
// -----------------------------------------------------------------------------
// seq_stage_controller
// Sequences the SEQ Y86-64 datapath one stage per state:
// FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PCUPDATE -> FETCH.
// All outputs are registered and reflect the state the controller is in.
// Optional feature macro: SEQ_PERF_CNT_EN adds cyc_cnt / ins_cnt counters.
// Ports:
//   clk, rst_n         clock (rising) / async active-low reset
//   start              leave IDLE (sampled in IDLE only)
//   icode              instruction code, latched in DECODE
//   instr_valid        fetch found a legal instruction
//   imem_error         fetch address error
//   cnd                condition result, latched in MEMORY
//   mem_ready          data memory completed the request
//   dmem_error         data memory address error (qualified by mem_ready)
//   stage_en[5:0]      one-hot {pcupd,wb,mem,exe,dec,fetch}
//   mem_req            data memory request, held until mem_ready
//   wr_e_en / wr_m_en  register-file write enables (WRITEBACK)
//   stat[1:0]          AOK/HLT/ADR/INS
//   busy               high outside IDLE/HALT
//   cyc_cnt, ins_cnt   performance counters (SEQ_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module seq_stage_controller
    import y86_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
`ifdef SEQ_PERF_CNT_EN
    , parameter int CNT_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       icode,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             cnd,
    input  logic             mem_ready,
    input  logic             dmem_error,
    output logic [STG_W-1:0] stage_en,
    output logic             mem_req,
    output logic             wr_e_en,
    output logic             wr_m_en,
    output logic [1:0]       stat,
    output logic             busy
`ifdef SEQ_PERF_CNT_EN
    , output logic [CNT_W-1:0] cyc_cnt
    , output logic [CNT_W-1:0] ins_cnt
`endif
);

    localparam int               TMO_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

    state_e           state_q,    state_d;
    logic [1:0]       stat_q,     stat_d;
    logic [TMO_W-1:0] tmo_q,      tmo_d;
    logic [3:0]       icode_q,    icode_d;
    logic             cnd_q,      cnd_d;
    logic [STG_W-1:0] stage_en_q, stage_en_d;
    logic             mem_req_q,  mem_req_d;
    logic             wr_e_q,     wr_e_d;
    logic             wr_m_q,     wr_m_d;
    logic             busy_q,     busy_d;

    // Next-state, status, timeout and latch logic.
    always_comb begin
        state_d = state_q;
        stat_d  = stat_q;
        tmo_d   = tmo_q;
        icode_d = icode_q;
        cnd_d   = cnd_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                // An address error outranks an illegal instruction.
                if (imem_error) begin
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else if (!instr_valid) begin
                    state_d = S_HALT;
                    stat_d  = STAT_INS;
                end else begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                icode_d = icode;
                if (icode == I_HALT) begin
                    state_d = S_HALT;
                    stat_d  = STAT_HLT;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                state_d = S_MEMORY;
                tmo_d   = '0;
            end
            S_MEMORY: begin
                cnd_d = cnd;
                if (!is_mem_icode(icode_q)) begin
                    state_d = S_WRITEBACK;
                end else if (mem_ready) begin
                    if (dmem_error) begin
                        state_d = S_HALT;
                        stat_d  = STAT_ADR;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // This was the MEM_TIMEOUT-th cycle without a response.
                    state_d = S_HALT;
                    stat_d  = STAT_ADR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_WRITEBACK: begin
                state_d = S_PCUPDATE;
            end
            S_PCUPDATE: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state the controller is in. cnd_d is used so that the value
    // sampled on the last MEMORY cycle governs the cmovxx write.
    always_comb begin
        stage_en_d = stage_onehot(state_d);
        mem_req_d  = (state_d == S_MEMORY)    && is_mem_icode(icode_q);
        wr_e_d     = (state_d == S_WRITEBACK) && writes_e(icode_q, cnd_d);
        wr_m_d     = (state_d == S_WRITEBACK) && writes_m(icode_q);
        busy_d     = (state_d != S_IDLE) && (state_d != S_HALT);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stat_q     <= STAT_AOK;
            tmo_q      <= '0;
            icode_q    <= I_HALT;
            cnd_q      <= 1'b0;
            stage_en_q <= '0;
            mem_req_q  <= 1'b0;
            wr_e_q     <= 1'b0;
            wr_m_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            stat_q     <= stat_d;
            tmo_q      <= tmo_d;
            icode_q    <= icode_d;
            cnd_q      <= cnd_d;
            stage_en_q <= stage_en_d;
            mem_req_q  <= mem_req_d;
            wr_e_q     <= wr_e_d;
            wr_m_q     <= wr_m_d;
            busy_q     <= busy_d;
        end
    end

    assign stage_en = stage_en_q;
    assign mem_req  = mem_req_q;
    assign wr_e_en  = wr_e_q;
    assign wr_m_en  = wr_m_q;
    assign stat     = stat_q;
    assign busy     = busy_q;

`ifdef SEQ_PERF_CNT_EN
    logic ins_en_s;
    assign ins_en_s = (state_q == S_PCUPDATE);

    seq_perf_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (busy_q),
        .cnt_o (cyc_cnt)
    );

    seq_perf_counter #(.CNT_W(CNT_W)) u_ins_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (ins_en_s),
        .cnt_o (ins_cnt)
    );
`endif

endmodule
